// File: rtl/pool_window_sched.sv
// pool_window_sched: walks a square feature map in window-major order for the pooling unit and writes pooled results.
// Build option POOL_SCHED_CH_LOOP_EN adds a num_ch input that repeats the walk per channel.
module pool_window_sched #(
  parameter int DW     = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        fm_dim,
  input  logic              k2,
`ifdef POOL_SCHED_CH_LOOP_EN
  input  logic [3:0]        num_ch,
`endif
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pool_en,
  output logic              pool_input_flag,
  output logic [2:0]        pool_kernel_dim2,
  input  logic              pool_output_flag,
  input  logic [2*DW-1:0]   pool_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2*DW-1:0]   wr_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  // Strobe semantics (no backpressure anywhere): rd_en qualifies rd_addr and the
  // buffer returns data one cycle later; wr_en qualifies wr_addr/wr_data in the same cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  state_t state;

  logic              kk;
  logic [4:0]        dim, od_m1, wx, wy;
  logic              kx, ky;
  logic [ADDR_W-1:0] win_addr, wrow_addr;
  logic [13:0]       wr_cnt, wr_total, wr_cnt_nxt, total_in;
  logic [4:0]        od_in;
  logic [9:0]        od_sq;
  logic              win_end, row_end, map_end, last_read;
  logic [ADDR_W-1:0] dim_a, kstep, rstep;

  assign od_in = k2 ? {1'b0, fm_dim[4:1]} : fm_dim;
  assign od_sq = {5'b0, od_in} * {5'b0, od_in};

`ifdef POOL_SCHED_CH_LOOP_EN
  logic [3:0]        ch, ch_last, nch_in;
  logic [ADDR_W-1:0] ch_base, fm_sq;
  logic [9:0]        fm_sq_in;
  assign nch_in    = (num_ch == 4'd0) ? 4'd1 : num_ch;
  assign total_in  = {4'b0, od_sq} * {10'b0, nch_in};
  assign fm_sq_in  = {5'b0, fm_dim} * {5'b0, fm_dim};
  assign last_read = win_end && map_end && (ch == ch_last);
`else
  assign total_in  = {4'b0, od_sq};
  assign last_read = win_end && map_end;
`endif

  assign win_end    = !kk || (kx && ky);
  assign row_end    = (wx == od_m1);
  assign map_end    = row_end && (wy == od_m1);
  assign dim_a      = ADDR_W'(dim);
  assign kstep      = kk ? ADDR_W'(2) : ADDR_W'(1);
  assign rstep      = kk ? (dim_a << 1) : dim_a;
  assign wr_cnt_nxt = wr_cnt + {13'b0, pool_output_flag};

  assign wr_en     = pool_output_flag;
  assign wr_data   = pool_data;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rd_en            <= 1'b0;
      rd_addr          <= '0;
      pool_en          <= 1'b0;
      pool_input_flag  <= 1'b0;
      pool_kernel_dim2 <= 3'd4;
      wr_addr          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      kk               <= 1'b0;
      dim              <= '0;
      od_m1            <= '0;
      wx               <= '0;
      wy               <= '0;
      kx               <= 1'b0;
      ky               <= 1'b0;
      win_addr         <= '0;
      wrow_addr        <= '0;
      wr_cnt           <= '0;
      wr_total         <= '0;
`ifdef POOL_SCHED_CH_LOOP_EN
      ch               <= '0;
      ch_last          <= '0;
      ch_base          <= '0;
      fm_sq            <= '0;
`endif
    end else begin
      pool_input_flag <= rd_en;
      if ((state == RUN || state == DRAIN) && pool_output_flag) begin
        wr_addr <= wr_addr + ADDR_W'(1);
        wr_cnt  <= wr_cnt_nxt;
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            kk               <= k2;
            dim              <= fm_dim;
            od_m1            <= od_in - 5'd1;
            pool_kernel_dim2 <= k2 ? 3'd4 : 3'd1;
            wx               <= '0;
            wy               <= '0;
            kx               <= 1'b0;
            ky               <= 1'b0;
            rd_addr          <= rd_base;
            win_addr         <= rd_base;
            wrow_addr        <= rd_base;
            wr_addr          <= wr_base;
            wr_cnt           <= '0;
            wr_total         <= total_in;
`ifdef POOL_SCHED_CH_LOOP_EN
            ch               <= '0;
            ch_last          <= nch_in - 4'd1;
            ch_base          <= rd_base;
            fm_sq            <= ADDR_W'(fm_sq_in);
`endif
            if (od_in == 5'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= RUN;
              rd_en   <= 1'b1;
              pool_en <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!win_end) begin
            // Inside a 2x2 window: step right, then down-left to the second row.
            if (!kx) begin
              rd_addr <= rd_addr + ADDR_W'(1);
              kx      <= 1'b1;
            end else begin
              rd_addr <= rd_addr + dim_a - ADDR_W'(1);
              kx      <= 1'b0;
              ky      <= 1'b1;
            end
          end else begin
            kx <= 1'b0;
            ky <= 1'b0;
            if (last_read) begin
              rd_en <= 1'b0;
              state <= DRAIN;
            end else if (!row_end) begin
              wx       <= wx + 5'd1;
              win_addr <= win_addr + kstep;
              rd_addr  <= win_addr + kstep;
            end else if (!map_end) begin
              wx        <= '0;
              wy        <= wy + 5'd1;
              wrow_addr <= wrow_addr + rstep;
              win_addr  <= wrow_addr + rstep;
              rd_addr   <= wrow_addr + rstep;
            end
`ifdef POOL_SCHED_CH_LOOP_EN
            else begin
              // Next channel starts a full map further on, with no bubble.
              ch        <= ch + 4'd1;
              wx        <= '0;
              wy        <= '0;
              ch_base   <= ch_base + fm_sq;
              wrow_addr <= ch_base + fm_sq;
              win_addr  <= ch_base + fm_sq;
              rd_addr   <= ch_base + fm_sq;
            end
`endif
          end
        end
        DRAIN: begin
          if (wr_cnt_nxt >= wr_total) begin
            state   <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            pool_en <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_window_sched.sv
// Bench for pool_window_sched: buffer + max-pool unit models, reference read/write schedule, scoreboard monitor.
`timescale 1ns/1ps
module tb_pool_window_sched;
  localparam int DW = 8;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [4:0]        fm_dim = '0;
  logic              k2 = 1'b0;
`ifdef POOL_SCHED_CH_LOOP_EN
  logic [3:0]        num_ch = '0;
`endif
  logic [ADDR_W-1:0] rd_base = '0;
  logic [ADDR_W-1:0] wr_base = '0;
  logic              rd_en, pool_en, pool_input_flag, wr_en, busy, done;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [2:0]        pool_kernel_dim2;
  logic              pool_output_flag;
  logic [2*DW-1:0]   pool_data, wr_data;
  logic [1:0]        state_dbg;

  pool_window_sched #(.DW(DW), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fm_dim(fm_dim), .k2(k2),
`ifdef POOL_SCHED_CH_LOOP_EN
    .num_ch(num_ch),
`endif
    .rd_base(rd_base), .wr_base(wr_base), .rd_en(rd_en), .rd_addr(rd_addr),
    .pool_en(pool_en), .pool_input_flag(pool_input_flag), .pool_kernel_dim2(pool_kernel_dim2),
    .pool_output_flag(pool_output_flag), .pool_data(pool_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- read buffer + max-pooling unit models ----------------
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] buf_q, pacc, pm;
  logic [2:0]    pcnt;
  logic          pflag;
  logic [2*DW-1:0] pdata;
  assign pool_output_flag = pflag;
  assign pool_data = pdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0; pacc <= '0; pcnt <= '0; pflag <= 1'b0; pdata <= '0;
    end else begin
      if (rd_en) buf_q <= mem[rd_addr];
      pflag <= 1'b0;
      if (!pool_en) begin
        pcnt <= '0; pacc <= '0;
      end else if (pool_input_flag) begin
        pm = (pcnt == 3'd0 || buf_q > pacc) ? buf_q : pacc;
        if (pcnt + 3'd1 == pool_kernel_dim2) begin
          pflag <= 1'b1; pdata <= {{DW{1'b0}}, pm}; pcnt <= '0; pacc <= '0;
        end else begin
          pcnt <= pcnt + 3'd1; pacc <= pm;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_rd_q[$];
  logic [63:0] exp_wr_q[$];
  logic [63:0] e;
  bit chk_en = 1'b0;
  int busy_lo = 1, busy_hi = 0, done_cyc = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      chk("pool_en", pool_en, (cyc >= busy_lo && cyc <= busy_hi));
      chk("done", done, (cyc == done_cyc));
      if (rd_en) begin
        if (exp_rd_q.size() == 0) chk("rd_extra", 1, 0);
        else begin
          e = exp_rd_q.pop_front();
          chk("rd_addr", rd_addr, e[11:0]);
          chk("rd_cycle", cyc, e[63:32]);
        end
      end
      if (wr_en) begin
        if (exp_wr_q.size() == 0) chk("wr_extra", 1, 0);
        else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", wr_addr, e[27:16]);
          chk("wr_data", wr_data, e[15:0]);
          chk("wr_cycle", cyc, e[63:32]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Expected schedule from the window-walk rules: cycle s is the cycle whose closing edge samples start.
  task automatic build_exp(input int fd, input bit kk, input int rb, input int wb,
                           input int nch, input int s, output int r, output int od);
    int kn, nc, i, n;
    logic [11:0] a;
    logic [7:0] mx;
    kn = kk ? 2 : 1;
    nc = (nch == 0) ? 1 : nch;
    od = fd / kn;
    r = nc * od * od * kn * kn;
    i = 0; n = 0;
    for (int c = 0; c < nc; c++)
      for (int wy = 0; wy < od; wy++)
        for (int wx = 0; wx < od; wx++) begin
          mx = '0;
          for (int ky = 0; ky < kn; ky++)
            for (int kx = 0; kx < kn; kx++) begin
              a = 12'(rb + c * fd * fd + (wy * kn + ky) * fd + wx * kn + kx);
              exp_rd_q.push_back({32'(s + 1 + i), 20'd0, a});
              if (mem[a] > mx) mx = mem[a];
              i++;
            end
          exp_wr_q.push_back({32'(s + (n + 1) * kn * kn + 2), 4'd0, 12'(wb + n), 8'd0, mx});
          n++;
        end
    busy_lo = s + 1;
    busy_hi = (od > 0) ? s + r + 2 : s;
    done_cyc = (od > 0) ? s + r + 3 : s + 1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_start(input int fd, input bit kk, input int rb, input int wb, input int nch);
    start = 1'b1; fm_dim = 5'(fd); k2 = kk; rd_base = 12'(rb); wr_base = 12'(wb);
`ifdef POOL_SCHED_CH_LOOP_EN
    num_ch = 4'(nch);
`endif
  endtask

  task automatic run_job(input int fd, input bit kk, input int rb, input int wb, input int nch);
    int s, r, od;
    bit got;
    @(negedge clk); #1;
    s = cyc;
    build_exp(fd, kk, rb, wb, nch, s, r, od);
    drive_start(fd, kk, rb, wb, nch);
    @(negedge clk); #1;
    start = 1'b0;
    chk("kdim2", pool_kernel_dim2, kk ? 4 : 1);
    got = 1'b0;
    for (int t = 0; t < r + 20; t++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("done_seen", got, 1);
    chk("rd_left", exp_rd_q.size(), 0);
    chk("wr_left", exp_wr_q.size(), 0);
    exp_rd_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic chk_reset_vals();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_pool_en", pool_en, 0);
    chk("rst_input_flag", pool_input_flag, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_kdim2", pool_kernel_dim2, 4);
    chk("rst_state", state_dbg, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s, r, od, nch;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom_range(0, 255));
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals();
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_job(4, 1'b1, 0, 100, 1);
    run_job(5, 1'b1, 200, 300, 1);
    run_job(3, 1'b0, 50, 400, 1);
    run_job(1, 1'b1, 10, 500, 1);
    run_job(0, 1'b0, 10, 500, 1);
    run_job(1, 1'b0, 4095, 4095, 1);

    repeat (12) begin
`ifdef POOL_SCHED_CH_LOOP_EN
      nch = $urandom_range(0, 3);
`else
      nch = 1;
`endif
      run_job($urandom_range(0, 13), 1'($urandom_range(0, 1)), $urandom_range(0, 4095),
              $urandom_range(0, 4095), nch);
    end

    // 28x28 job: stray start while busy, then reset during cycle 7.
    @(negedge clk); #1;
    s = cyc;
    build_exp(28, 1'b1, 1000, 2000, 1, s, r, od);
    drive_start(28, 1'b1, 1000, 2000, 1);
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    drive_start(4, 1'b0, 7, 9, 1);
    @(negedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(negedge clk); #1; end
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    chk_en = 1'b0;
    #1;
    chk_reset_vals();
    exp_rd_q.delete();
    exp_wr_q.delete();
    busy_lo = 1; busy_hi = 0; done_cyc = -1;
    @(negedge clk); #1;
    chk_reset_vals();
    rst_n = 1'b1;
    chk_en = 1'b1;
    run_job(6, 1'b1, 3000, 3500, 1);

`ifdef POOL_SCHED_CH_LOOP_EN
    run_job(4, 1'b1, 0, 100, 2);
    run_job(5, 1'b1, 4000, 4090, 3);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
